// File: rtl/n64_vinfo_tracker.sv
// Video-info tracker for the N64 digital video bus: data phase, PAL/NTSC, 240p/480i, line counts.
// Optional VSYNC-loss detection is compiled in with `define VINFO_SYNC_LOSS_EN.
module n64_vinfo_tracker #(
    parameter int DCNT_W          = 2,
    parameter int LINE_W          = 10,
    parameter int PAL_LINE_THRESH = 288,
    parameter int LOCK_FRAMES     = 2,
    parameter int SYNC_LOSS_LINES = 400
) (
    input  logic              VCLK,
    input  logic              RST,
    input  logic              nDSYNC,
    input  logic [3:0]        Sync_pre,
    input  logic [3:0]        Sync_cur,
    output logic [DCNT_W-1:0] data_cnt,
    output logic              vmode,
    output logic              n64_480i,
    output logic              field_id,
    output logic [LINE_W-1:0] line_cnt,
    output logic [LINE_W-1:0] lines_per_field,
    output logic              vinfo_valid,
    output logic              sync_lost
);

    localparam logic [LINE_W-1:0] PAL_TH   = LINE_W'(PAL_LINE_THRESH);
    localparam logic [LINE_W-1:0] LINE_MAX = '1;
    localparam logic [3:0]        LOCK_N   = 4'(LOCK_FRAMES);
`ifdef VINFO_SYNC_LOSS_EN
    localparam logic [LINE_W-1:0] LOSS_M1  = LINE_W'(SYNC_LOSS_LINES - 1);
`endif

    if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_lock
        $error("LOCK_FRAMES must be in 1..15");
    end
    if (SYNC_LOSS_LINES < 1 || SYNC_LOSS_LINES >= (1 << LINE_W)) begin : g_bad_loss
        $error("SYNC_LOSS_LINES must be in 1..2^LINE_W-1");
    end

    // Returns {new_value, new_stab}: a change is accepted only after LOCK_N agreeing fields in a row.
    function automatic logic [4:0] hyst(input logic cand, input logic cur, input logic [3:0] stab);
        if (cand == cur)
            return {cur, 4'd0};
        else if (stab + 4'd1 == LOCK_N)
            return {cand, 4'd0};
        else
            return {cur, stab + 4'd1};
    endfunction

    logic pos_v, neg_v, pos_h, neg_h;
    assign pos_v = !nDSYNC & !Sync_pre[3] &  Sync_cur[3];
    assign neg_v = !nDSYNC &  Sync_pre[3] & !Sync_cur[3];
    assign pos_h = !nDSYNC & !Sync_pre[1] &  Sync_cur[1];
    assign neg_h = !nDSYNC &  Sync_pre[1] & !Sync_cur[1];

    logic unused_sync_bits;
    assign unused_sync_bits = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};

    logic [3:0]        vstab, istab, vstab_d, istab_d;
    logic [1:0]        vcnt, vcnt_d;
    logic              prev_field, prev_field_d, neg_seen, neg_seen_d;
    logic [DCNT_W-1:0] data_cnt_d;
    logic [LINE_W-1:0] line_cnt_d, lines_per_field_d;
    logic              vmode_d, n64_480i_d, field_id_d, sync_lost_d;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
        data_cnt_d        = nDSYNC ? data_cnt + 1'b1 : DCNT_W'(1);
        line_cnt_d        = line_cnt;
        lines_per_field_d = lines_per_field;
        vmode_d           = vmode;
        vstab_d           = vstab;
        n64_480i_d        = n64_480i;
        istab_d           = istab;
        field_id_d        = field_id;
        prev_field_d      = prev_field;
        neg_seen_d        = neg_seen;
        vcnt_d            = vcnt;
        sync_lost_d       = 1'b0;

        // A VSYNC rise closes the field; a coincident HSYNC rise is not counted.
        if (pos_v) begin
            lines_per_field_d = line_cnt;
            line_cnt_d        = '0;
            if (vcnt != 2'd0)
                {vmode_d, vstab_d} = hyst(line_cnt >= PAL_TH, vmode, vstab);
            if (vcnt != 2'd3)
                vcnt_d = vcnt + 2'd1;
        end else if (pos_h && line_cnt != LINE_MAX) begin
            line_cnt_d = line_cnt + 1'b1;
        end

        // Odd fields start with HSYNC falling together with VSYNC.
        if (neg_v) begin
            field_id_d   = neg_h;
            prev_field_d = neg_h;
            neg_seen_d   = 1'b1;
            if (neg_seen)
                {n64_480i_d, istab_d} = hyst(neg_h != prev_field, n64_480i, istab);
        end

`ifdef VINFO_SYNC_LOSS_EN
        sync_lost_d = sync_lost & ~pos_v;
        if (pos_h && !pos_v && line_cnt == LOSS_M1) begin
            sync_lost_d = 1'b1;
            vcnt_d      = '0;
        end
`endif
    end

    assign vinfo_valid = vcnt[1];

    always_ff @(posedge VCLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        data_cnt        <= data_cnt_d;
        line_cnt        <= line_cnt_d;
        lines_per_field <= lines_per_field_d;
        vmode           <= vmode_d;
        vstab           <= vstab_d;
        n64_480i        <= n64_480i_d;
        istab           <= istab_d;
        field_id        <= field_id_d;
        prev_field      <= prev_field_d;
        neg_seen        <= neg_seen_d;
        vcnt            <= vcnt_d;
        sync_lost       <= sync_lost_d;
        // Reset is evaluated last so it overrides any event in the same cycle.
        if (RST) begin
            data_cnt        <= '0;
            line_cnt        <= '0;
            lines_per_field <= '0;
            vmode           <= 1'b0;
            vstab           <= '0;
            n64_480i        <= 1'b0;
            istab           <= '0;
            field_id        <= 1'b0;
            prev_field      <= 1'b0;
            neg_seen        <= 1'b0;
            vcnt            <= '0;
            sync_lost       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_n64_vinfo_tracker.sv
// Directed self-checking bench for n64_vinfo_tracker (default DUT plus a LOCK_FRAMES=1 instance).
// Sync-loss expectations follow VINFO_SYNC_LOSS_EN when the bundle is built with it.
module tb_n64_vinfo_tracker;

`ifdef VINFO_SYNC_LOSS_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       VCLK = 1'b0;
    logic       RST;
    logic       nDSYNC;
    logic [3:0] Sync_pre, Sync_cur;

    logic [1:0] data_cnt,    data_cnt_1;
    logic       vmode,       vmode_1;
    logic       n64_480i,    n64_480i_1;
    logic       field_id,    field_id_1;
    logic [9:0] line_cnt,    line_cnt_1;
    logic [9:0] lpf,         lpf_1;
    logic       vinfo_valid, vinfo_valid_1;
    logic       sync_lost,   sync_lost_1;

    int n_checks = 0;
    int n_pass   = 0;
    int gap      = 3;

    always #5 VCLK = ~VCLK;

    n64_vinfo_tracker u_dut (
        .VCLK(VCLK), .RST(RST), .nDSYNC(nDSYNC), .Sync_pre(Sync_pre), .Sync_cur(Sync_cur),
        .data_cnt(data_cnt), .vmode(vmode), .n64_480i(n64_480i), .field_id(field_id),
        .line_cnt(line_cnt), .lines_per_field(lpf), .vinfo_valid(vinfo_valid), .sync_lost(sync_lost)
    );

    n64_vinfo_tracker #(.LOCK_FRAMES(1)) u_dut_l1 (
        .VCLK(VCLK), .RST(RST), .nDSYNC(nDSYNC), .Sync_pre(Sync_pre), .Sync_cur(Sync_cur),
        .data_cnt(data_cnt_1), .vmode(vmode_1), .n64_480i(n64_480i_1), .field_id(field_id_1),
        .line_cnt(line_cnt_1), .lines_per_field(lpf_1), .vinfo_valid(vinfo_valid_1),
        .sync_lost(sync_lost_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {data_cnt, vmode, n64_480i, field_id, line_cnt, lpf, vinfo_valid, sync_lost}, 0);
    endtask

    // One qualified sample cycle followed by `gap` unqualified cycles.
    task automatic step(input logic [3:0] pre, input logic [3:0] cur);
        nDSYNC = 1'b0; Sync_pre = pre; Sync_cur = cur;
        @(posedge VCLK); #1;
        nDSYNC = 1'b1; Sync_pre = cur;
        for (int i = 0; i < gap; i++) begin
            @(posedge VCLK); #1;
        end
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            step(4'b1010, 4'b1000);
            step(4'b1000, 4'b1010);
        end
    endtask

    // VSYNC pulse (with HSYNC low during it on odd fields), then n counted lines.
    task automatic field(input int n, input bit odd);
        step(4'b1010, odd ? 4'b0000 : 4'b0010);
        step(odd ? 4'b0000 : 4'b0010, 4'b1010);
        lines(n);
    endtask

    initial begin
        RST = 1'b1; nDSYNC = 1'b1; Sync_pre = 4'b1010; Sync_cur = 4'b1010;
        repeat (2) @(posedge VCLK);
        #1;
        check_zero("reset_state");
        RST = 1'b0;

        // data_cnt: 1 on the sync cycle, then 2,3,0
        nDSYNC = 1'b0;
        @(posedge VCLK); #1;
        check("data_cnt[0]", data_cnt, 1);
        nDSYNC = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(posedge VCLK); #1;
            check("data_cnt_seq", data_cnt, (i + 1) % 4);
        end

        // NTSC 240p
        field(263, 0);
        check("f1_not_valid", vinfo_valid, 0);
        check("f1_line_cnt", line_cnt, 263);
        field(263, 0);
        check("f2_lpf", lpf, 263);
        check("f2_valid", vinfo_valid, 1);
        check("f2_vmode", vmode, 0);
        check("f2_480i", n64_480i, 0);

        // PAL lock-in with hysteresis
        gap = 1;
        field(313, 0);
        field(313, 0);
        check("f4_lpf", lpf, 313);
        check("f4_vmode_hold", vmode, 0);
        check("f4_vmode_lock1", vmode_1, 1);
        field(263, 0);
        check("f5_vmode_pal", vmode, 1);
        field(313, 0);
        field(263, 0);
        field(313, 0);
        check("f8_lpf", lpf, 263);
        check("f8_vmode_stray", vmode, 1);
        check("f8_vmode_lock1", vmode_1, 0);

        // Interlace detection
        field(263, 1);
        check("i1_field_id", field_id, 1);
        check("i1_480i_hold", n64_480i, 0);
        check("i1_480i_lock1", n64_480i_1, 1);
        field(263, 0);
        check("i2_field_id", field_id, 0);
        check("i2_480i", n64_480i, 1);
        field(263, 1);
        check("i3_480i", n64_480i, 1);
        field(263, 0);
        field(263, 0);
        check("i5_480i_hold", n64_480i, 1);
        field(150, 0);
        check("i6_480i_off", n64_480i, 0);
        check("i6_lpf", lpf, 263);

        // Unqualified VSYNC/HSYNC rise is ignored
        nDSYNC = 1'b1; Sync_pre = 4'b0000; Sync_cur = 4'b1010;
        @(posedge VCLK); #1;
        Sync_pre = 4'b1010;
        @(posedge VCLK); #1;
        check("unqual_line_cnt", line_cnt, 150);
        check("unqual_lpf", lpf, 263);

        // posV with posH on the same cycle: prior count kept, not +1
        field(100, 1);
        check("posv_posh_lpf", lpf, 150);
        check("posv_posh_line_cnt", line_cnt, 100);
        lines(50);
        check("pre_reset_line_cnt", line_cnt, 150);

        // Mid-field reset overriding a qualified posV
        RST = 1'b1; nDSYNC = 1'b0; Sync_pre = 4'b0010; Sync_cur = 4'b1010;
        @(posedge VCLK); #1;
        check_zero("mid_reset");
        RST = 1'b0; nDSYNC = 1'b1; Sync_pre = 4'b1010;
        field(263, 0);
        check("post_reset_not_valid", vinfo_valid, 0);
        check("post_reset_lpf", lpf, 0);
        field(263, 0);
        check("post_reset_valid", vinfo_valid, 1);
        check("post_reset_lpf2", lpf, 263);

        // VSYNC withheld
        lines(136);
        check("l399_sync_lost", sync_lost, 0);
        check("l399_valid", vinfo_valid, 1);
        lines(1);
        check("l400_line_cnt", line_cnt, 400);
        check("l400_sync_lost", sync_lost, LOSS_EN);
        check("l400_valid", vinfo_valid, !LOSS_EN);
        lines(700);
        check("line_cnt_sat", line_cnt, 1023);
        check("vmode_held", vmode, 0);
        field(263, 0);
        check("recover_lpf", lpf, 1023);
        check("recover_sync_lost", sync_lost, 0);
        check("recover_valid", vinfo_valid, !LOSS_EN);
        field(263, 0);
        check("recover_valid2", vinfo_valid, 1);
        check("recover_lpf2", lpf, 263);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
